time_entry_buffer: RTL and testbench

Parametrised, clocked keypad time-entry buffer for the alarm clock. It takes decoded 4-bit key codes from the keypad/debounce path and assembles a BCD time of 1–3 fields (HH, HH:MM, or HH:MM:SS) with per-digit range validation, backspace, clear and an inactivity timeout. It validates the complete value against 12 h or 24 h mode on Enter and delivers it as a committed word with a one-cycle valid pulse to the alarm/time-set registers.

---
 rtl/time_entry_pkg.sv | 13 +
 rtl/key_event_detect.sv | 20 ++
 rtl/time_entry_buffer.sv | 112 +++++++++++
 tb/tb_time_entry_buffer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/time_entry_pkg.sv
// time_entry_pkg: key codes, entry FSM states and per-digit range limits
package time_entry_pkg;
  localparam logic [3:0] KEY_CLEAR = 4'hB;
  localparam logic [3:0] KEY_BKSP  = 4'hD;
  localparam logic [3:0] KEY_ENTER = 4'hE;
  typedef enum logic [1:0] {EMPTY, EDIT, FULL} state_t;
  // Largest digit allowed at position pos; the 12 h "no hour 00" floor is checked separately
  function automatic logic [3:0] digit_limit(input int pos, input logic m12, input logic [3:0] tens);
    return pos == 0 ? (m12 ? 4'd1 : 4'd2) :
           pos == 1 ? (m12 ? (tens == 4'd0 ? 4'd9 : 4'd2) : (tens == 4'd2 ? 4'd3 : 4'd9)) :
           pos[0] ? 4'd9 : 4'd5;
  endfunction
endpackage

// File: rtl/key_event_detect.sv
// key_event_detect: strobe falling-edge pulse with the code held from the last strobe-high cycle
module key_event_detect (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_strobe,
  input  logic [3:0] key_code,
  output logic       key_event,
  output logic [3:0] code
);
  logic strobe_q;
  always_ff @(posedge clk)
    if (reset) begin
      strobe_q <= 1'b0;
      code <= 4'h0;
    end else begin
      strobe_q <= key_strobe;
      if (key_strobe) code <= key_code;
    end
  assign key_event = strobe_q & ~key_strobe;
endmodule

// File: rtl/time_entry_buffer.sv
// time_entry_buffer: keypad BCD time entry with validation, backspace, clear, timeout and commit
module time_entry_buffer
  import time_entry_pkg::*;
#(
  parameter int NUM_FIELDS = 3,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [3:0]                        key_code,
  input  logic                              key_strobe,
  input  logic                              enable,
  input  logic                              mode_12h,
  output logic [8*NUM_FIELDS-1:0]           entry,
  output logic [$clog2(2*NUM_FIELDS+1)-1:0] cursor,
  output logic                              full,
  output logic [8*NUM_FIELDS-1:0]           time_out,
  output logic                              time_valid,
  output logic                              key_error
);
  localparam int ND = 2 * NUM_FIELDS;
  localparam int W = 8 * NUM_FIELDS;
  localparam int CW = $clog2(ND + 1);
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  logic          ev_raw;
  logic          ev;
  logic [3:0]    code;
  logic [3:0]    tens;
  logic [3:0]    units;
  logic          digit_ok;
  logic          hour_ok;
  logic          expire;
  logic [TW-1:0] tcnt;
  state_t        state;
  state_t        state_n;
  logic [W-1:0]  entry_n;
  logic [W-1:0]  time_out_n;
  logic [CW-1:0] cursor_n;
  logic          valid_n;
  logic          err_n;
  key_event_detect u_detect (
    .clk(clk),
    .reset(reset),
    .key_strobe(key_strobe),
    .key_code(key_code),
    .key_event(ev_raw),
    .code(code)
  );
  assign ev = ev_raw & enable;
  assign tens = entry[W-1 -: 4];
  assign units = entry[W-5 -: 4];
  assign digit_ok = code <= digit_limit(int'(cursor), mode_12h, tens) &&
                    !(cursor == CW'(1) && mode_12h && tens == 4'd0 && code == 4'd0);
  // Whole hour re-checked at commit so a mode flip after the hour digits is caught
  assign hour_ok = tens <= digit_limit(0, mode_12h, 4'd0) &&
                   units <= digit_limit(1, mode_12h, tens) &&
                   !(mode_12h && tens == 4'd0 && units == 4'd0);
  assign expire = TIMEOUT_CYCLES != 0 && cursor != '0 && tcnt == TW'(TIMEOUT_CYCLES - 1);
  assign full = state == FULL;
  always_comb begin
    entry_n = entry;
    cursor_n = cursor;
    time_out_n = time_out;
    valid_n = 1'b0;
    err_n = 1'b0;
    if (ev) begin
      if (code <= 4'd9) begin
        if (state != FULL && digit_ok) begin
          entry_n[(ND - 1 - int'(cursor)) * 4 +: 4] = code;
          cursor_n = cursor + 1'b1;
        end else err_n = 1'b1;
      end else if (code == KEY_BKSP) begin
        if (cursor != '0) begin
          entry_n[(ND - int'(cursor)) * 4 +: 4] = 4'h0;
          cursor_n = cursor - 1'b1;
        end else err_n = 1'b1;
      end else if (code == KEY_CLEAR) begin
        entry_n = '0;
        cursor_n = '0;
      end else if (code == KEY_ENTER) begin
        if (state == FULL && hour_ok) begin
          time_out_n = entry;
          valid_n = 1'b1;
          entry_n = '0;
          cursor_n = '0;
        end else err_n = 1'b1;
      end
    end else if (expire) begin
      entry_n = '0;
      cursor_n = '0;
    end
    state_n = cursor_n == '0 ? EMPTY : cursor_n == CW'(ND) ? FULL : EDIT;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= EMPTY;
      entry <= '0;
      cursor <= '0;
      time_out <= '0;
      time_valid <= 1'b0;
      key_error <= 1'b0;
    end else begin
      state <= state_n;
      entry <= entry_n;
      cursor <= cursor_n;
      time_out <= time_out_n;
      time_valid <= valid_n;
      key_error <= err_n;
    end
  always_ff @(posedge clk)
    tcnt <= (reset || ev || expire || cursor == '0) ? '0 : tcnt + 1'b1;
endmodule

// File: tb/tb_time_entry_buffer.sv
// tb_time_entry_buffer: directed plan plus random keys against a digit-array reference model
module tb_time_entry_buffer;
  localparam int TO = 16;
  typedef struct packed {
    logic        kind;
    logic [23:0] val;
    logic [31:0] stamp;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        key_strobe = 1'b0;
  logic        enable = 1'b1;
  logic        mode_12h = 1'b0;
  logic [23:0] entry;
  logic [2:0]  cursor;
  logic        full;
  logic [23:0] time_out;
  logic        time_valid;
  logic        key_error;
  int          passed = 0;
  int          total = 0;
  exp_t        expq[$];
  int          md[6];
  int          mn = 0;
  int          idle = 0;
  logic [23:0] mto = '0;
  logic        mprev = 1'b0;
  logic [3:0]  mcode = 4'h0;
  logic [31:0] cy = 0;
  logic        m12 = 1'b0;
  time_entry_buffer #(.NUM_FIELDS(3), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .reset(reset),
    .key_code(key_code),
    .key_strobe(key_strobe),
    .enable(enable),
    .mode_12h(mode_12h),
    .entry(entry),
    .cursor(cursor),
    .full(full),
    .time_out(time_out),
    .time_valid(time_valid),
    .key_error(key_error)
  );
  always #5 clk = ~clk;
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction
  function automatic logic [23:0] pack();
    logic [23:0] v = '0;
    for (int i = 0; i < 6; i++) v[(5 - i) * 4 +: 4] = 4'(md[i]);
    return v;
  endfunction
  function automatic void mclear();
    for (int i = 0; i < 6; i++) md[i] = 0;
    mn = 0;
  endfunction
  function automatic bit hour_ok(input int h);
    return mode_12h ? (h >= 1 && h <= 12) : (h <= 23);
  endfunction
  function automatic bit dig_ok(input int p, input int d);
    if (p == 0) return mode_12h ? d <= 1 : d <= 2;
    if (p == 1) return hour_ok(10 * md[0] + d);
    return (p % 2 == 0) ? d <= 5 : 1'b1;
  endfunction
  function automatic void model_key(input int c);
    if (c <= 9) begin
      if (mn < 6 && dig_ok(mn, c)) begin
        md[mn] = c;
        mn++;
      end else expq.push_back({1'b0, mto, cy});
    end else if (c == 11) mclear();
    else if (c == 13) begin
      if (mn > 0) begin
        mn--;
        md[mn] = 0;
      end else expq.push_back({1'b0, mto, cy});
    end else if (c == 14) begin
      if (mn == 6 && hour_ok(10 * md[0] + md[1])) begin
        mto = pack();
        expq.push_back({1'b1, mto, cy});
        mclear();
      end else expq.push_back({1'b0, mto, cy});
    end
  endfunction
  function automatic void model_step();
    bit ev = mprev && !key_strobe && enable;
    cy++;
    if (reset) begin
      mclear();
      mto = '0;
      idle = 0;
      mprev = 1'b0;
      mcode = 4'h0;
      return;
    end
    if (ev) begin
      model_key(int'(mcode));
      idle = 0;
    end else if (mn > 0) begin
      if (idle == TO - 1) begin
        mclear();
        idle = 0;
      end else idle++;
    end else idle = 0;
    mprev = key_strobe;
    if (key_strobe) mcode = key_code;
  endfunction
  task automatic cyc(input logic s, input logic [3:0] c, input logic en, input logic rs);
    @(negedge clk);
    key_strobe = s;
    key_code = c;
    enable = en;
    reset = rs;
    mode_12h = m12;
    @(posedge clk);
    model_step();
    #1;
    chk("entry", entry, pack());
    chk("cursor", cursor, mn);
    chk("full", full, mn == 6);
    chk("time_out", time_out, mto);
  endtask
  task automatic press(input logic [3:0] c, input int hold, input int gap, input logic en);
    repeat (hold) cyc(1'b1, c, en, 1'b0);
    repeat (gap) cyc(1'b0, c, en, 1'b0);
  endtask
  task automatic k(input logic [3:0] c);
    press(c, 1, 1, 1'b1);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (time_valid || key_error) begin
        if (expq.size() == 0) begin
          total++;
          $display("FAIL spurious_pulse: time_valid=%b key_error=%b none expected", time_valid, key_error);
        end else begin
          e = expq.pop_front();
          chk("pulse_cycle", cy, e.stamp);
          chk("pulse_valid", time_valid, e.kind);
          chk("pulse_error", key_error, !e.kind);
          chk("pulse_time_out", time_out, e.val);
        end
      end else if (expq.size() != 0 && expq[0].stamp == cy) begin
        e = expq.pop_front();
        total++;
        $display("FAIL missing_pulse: no pulse, expected kind %b at cycle %0d", e.kind, e.stamp);
      end
    end
  end
  initial begin
    logic [3:0] c;
    repeat (2) cyc(1'b0, 4'h0, 1'b1, 1'b1);
    chk("rst_valid", time_valid, 0);
    chk("rst_error", key_error, 0);
    k(2); k(3); k(5); k(9); k(4); k(7); k(4'hE);
    chk("commit_valid", time_valid, 1);
    chk("commit_value", time_out, 24'h235947);
    chk("commit_cursor", cursor, 0);
    k(2); k(4);
    chk("h24_err", key_error, 1);
    chk("h24_entry", entry, 24'h200000);
    k(3);
    chk("h24_ok", entry, 24'h230000);
    chk("h24_cursor", cursor, 2);
    k(4'hB);
    m12 = 1'b1;
    k(0); k(0);
    chk("h12_00", key_error, 1);
    k(4'hB); k(1); k(3);
    chk("h12_13", key_error, 1);
    k(4'hB); k(1); k(2);
    chk("h12_12", entry, 24'h120000);
    k(4'hB);
    m12 = 1'b0;
    k(1); k(8); k(3); k(0); k(0); k(0);
    m12 = 1'b1;
    k(4'hE);
    chk("mode_flip_err", key_error, 1);
    chk("mode_flip_tout", time_out, 24'h235947);
    chk("mode_flip_full", full, 1);
    k(4'hB);
    m12 = 1'b0;
    k(4'hD);
    chk("bksp_empty", key_error, 1);
    k(1); k(2); k(4'hD);
    chk("bksp_entry", entry, 24'h100000);
    chk("bksp_cursor", cursor, 1);
    k(4'hB);
    chk("clear_entry", entry, 0);
    chk("clear_noerr", key_error, 0);
    k(1);
    repeat (TO - 1) cyc(1'b0, 4'h0, 1'b1, 1'b0);
    chk("timeout_before", cursor, 1);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    chk("timeout_cursor", cursor, 0);
    chk("timeout_noerr", key_error, 0);
    k(1); k(2); k(3);
    cyc(1'b0, 4'h0, 1'b1, 1'b1);
    chk("rst_mid_entry", entry, 0);
    chk("rst_mid_cursor", cursor, 0);
    chk("rst_mid_tout", time_out, 0);
    for (int i = 0; i < 600; i++) begin
      if ((mn == 0 || mn == 6) && $urandom_range(0, 4) == 0) m12 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) cyc(1'b0, 4'h0, 1'b1, 1'b1);
      if ($urandom_range(0, 3) == 0)
        c = $urandom_range(0, 2) == 0 ? 4'hB : ($urandom_range(0, 1) == 0 ? 4'hD : 4'hE);
      else
        c = 4'($urandom_range(0, 15));
      press(c, $urandom_range(1, 3), $urandom_range(0, 9) == 0 ? $urandom_range(14, 20) : $urandom_range(1, 3),
            $urandom_range(0, 9) != 0);
    end
    repeat (3) cyc(1'b0, 4'h0, 1'b1, 1'b0);
    chk("queue_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
